func_sel_decoder: RTL



---
 rtl/func_sel_pkg.sv | 37 +++
 rtl/fsel_settle_timer.sv | 28 ++
 rtl/func_sel_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/func_sel_pkg.sv
// Shared types and constants for the ALU function-select characteriser.
// Patterns step {a,b} through 00, 01, 10, 11.
package func_sel_pkg;

  localparam int CODE_W = 4;

  localparam logic [1:0] PAT_00 = 2'b00;
  localparam logic [1:0] PAT_01 = 2'b01;
  localparam logic [1:0] PAT_10 = 2'b10;
  localparam logic [1:0] PAT_11 = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] x;
    logic [CODE_W-1:0] y;
  } tt_t;

  function automatic logic [1:0] pat_ab(input logic [1:0] idx);
    logic [1:0] p;
    p = PAT_00;
    unique case (idx)
      2'd0: p = PAT_00;
      2'd1: p = PAT_01;
      2'd2: p = PAT_10;
      2'd3: p = PAT_11;
      default: p = PAT_00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fsel_settle_timer.sv
// Loadable down-counter timing how long each stimulus pattern settles.
// expire flags the last settle cycle (count of 1).
module fsel_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign expire = (cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/func_sel_decoder.sv
// Characterises an ALU function-generator slice by sweeping a/b and
// capturing x/y truth tables. Optional compare: FUNC_SEL_DECODER_CMP_EN.
module func_sel_decoder
  import func_sel_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              stim_a,
  output logic              stim_b,
  input  logic              obs_x,
  input  logic              obs_y,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] code_x,
  output logic [CODE_W-1:0] code_y,
  output logic              code_valid
`ifdef FUNC_SEL_DECODER_CMP_EN
  ,
  input  logic [CODE_W-1:0] exp_x,
  input  logic [CODE_W-1:0] exp_y,
  output logic              mismatch
`endif
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
        SETTLE_CYCLES >= (1 << CNT_W)) begin : g_bad_param
      $error("func_sel_decoder: SETTLE_CYCLES out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);

  state_t     state;
  logic [1:0] idx;
  tt_t        work;
  logic       t_load;
  logic       t_en;
  logic       expire;

  always_comb begin
    t_load = 1'b0;
    t_en   = 1'b0;
    unique case (state)
      IDLE:    t_load = start && !abort;
      SETTLE:  t_en   = 1'b1;
      SAMPLE:  t_load = !abort && (idx != 2'd3);
      default: t_load = 1'b0;
    endcase
  end

  fsel_settle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (LOAD_VAL),
    .en       (t_en),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      stim_a     <= 1'b0;
      stim_b     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      work       <= '0;
      code_x     <= '0;
      code_y     <= '0;
      code_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state            <= SETTLE;
            idx              <= 2'd0;
            {stim_a, stim_b} <= pat_ab(2'd0);
            busy             <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state            <= IDLE;
            {stim_a, stim_b} <= PAT_00;
            busy             <= 1'b0;
          end else if (expire) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state            <= IDLE;
            {stim_a, stim_b} <= PAT_00;
            busy             <= 1'b0;
          end else begin
            work.x[idx] <= obs_x;
            work.y[idx] <= obs_y;
            if (idx == 2'd3) begin
              state            <= DONE;
              {stim_a, stim_b} <= PAT_00;
              busy             <= 1'b0;
              done             <= 1'b1;
            end else begin
              state            <= SETTLE;
              idx              <= idx + 2'd1;
              {stim_a, stim_b} <= pat_ab(idx + 2'd1);
            end
          end
        end
        DONE: begin
          // abort is deliberately ignored so a finished sweep always lands
          code_x     <= work.x;
          code_y     <= work.y;
          code_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FUNC_SEL_DECODER_CMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
    end else if (state == DONE) begin
      mismatch <= (work.x != exp_x) | (work.y != exp_y);
    end
  end
`endif

endmodule
